// File: rtl/edge_threshold_pkg.sv
// Shared image geometry and FSM state type for the edge-threshold post-processor.
package edge_threshold_pkg;

  localparam int unsigned IMG_WIDTH     = 352;
  localparam int unsigned IMG_HEIGHT    = 288;
  localparam int unsigned WORDS_PER_ROW = 88;
  localparam int unsigned IMG_WORDS     = 25344;
  localparam int unsigned RESULT_BASE   = 25344;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/edge_threshold_if.sv
// Single-port word memory bus: read data returns the cycle after a read request.
interface edge_threshold_if;

  logic [15:0] addr;
  logic [31:0] dataR;
  logic [31:0] dataW;
  logic        en;
  logic        we;

  modport master (output addr, output dataW, output en, output we, input dataR);
  modport slave  (input addr, input dataW, input en, input we, output dataR);

endinterface

// File: rtl/edge_threshold_pix_thresh4.sv
// Binarises four packed 8-bit pixels against a threshold and counts the hits.
module pix_thresh4
  import edge_threshold_pkg::*;
(
  input  logic [31:0] word,
  input  logic [7:0]  thr,
  output logic [31:0] bin,
  output logic [2:0]  ones
);

  always_comb begin
    bin  = '0;
    ones = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (word[8*k +: 8] >= thr) begin
        bin[8*k +: 8] = '1;
        ones          = ones + 3'd1;
      end
    end
  end

endmodule

// File: rtl/edge_threshold.sv
// In-place binarisation of the Sobel result region: one read and one write per word.
module edge_threshold
  import edge_threshold_pkg::*;
#(
  parameter int unsigned BASE_ADDR = RESULT_BASE,
  parameter int unsigned NUM_WORDS = IMG_WORDS
)
(
  input  logic               clk,
  input  logic               reset,
  edge_threshold_if.master   mem,
  input  logic               start,
  input  logic [7:0]         threshold,
  output logic               finish,
  output logic [16:0]        edge_count
);

  localparam logic [14:0] LAST_IDX = 15'(NUM_WORDS - 1);
  localparam logic [15:0] BASE     = 16'(BASE_ADDR);

  state_t      state_q, state_d;
  logic [14:0] idx_q;
  logic [7:0]  thr_q;
  logic [16:0] count_q;
  logic [31:0] bin_word;
  logic [2:0]  bin_ones;
  logic [15:0] word_addr;

  assign word_addr  = BASE + {1'b0, idx_q};
  assign edge_count = count_q;

  // dataR holds the word fetched in READ throughout the following WRITE cycle
  pix_thresh4 u_thresh (
    .word (mem.dataR),
    .thr  (thr_q),
    .bin  (bin_word),
    .ones (bin_ones)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem.en    = 1'b0;
    mem.we    = 1'b0;
    mem.addr  = '0;
    mem.dataW = '0;
    finish    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = READ;
      end
      READ: begin
        mem.en   = 1'b1;
        mem.addr = word_addr;
        state_d  = WRITE;
      end
      WRITE: begin
        mem.en    = 1'b1;
        mem.we    = 1'b1;
        mem.addr  = word_addr;
        mem.dataW = bin_word;
        state_d   = (idx_q == LAST_IDX) ? DONE : READ;
      end
      DONE: begin
        finish = 1'b1;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= '0;
      thr_q   <= '0;
      count_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        idx_q   <= '0;
        thr_q   <= threshold;
        count_q <= '0;
      end else if (state_q == WRITE) begin
        count_q <= count_q + {14'd0, bin_ones};
        if (idx_q != LAST_IDX) idx_q <= idx_q + 15'd1;
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold.sv
// Scoreboarded random bench for edge_threshold on a reduced region against a byte-level model.
module tb_edge_threshold;

  localparam int unsigned BASE   = 100;
  localparam int unsigned NW     = 24;
  localparam int unsigned MEM_SZ = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  threshold = 8'd0;
  logic        finish;
  logic [16:0] edge_count;

  edge_threshold_if bus();

  edge_threshold #(.BASE_ADDR(BASE), .NUM_WORDS(NW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus),
    .start      (start),
    .threshold  (threshold),
    .finish     (finish),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem    [MEM_SZ];
  logic [31:0] shadow [MEM_SZ];
  logic [15:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // memory model: registered read, write on request
  always @(posedge clk) begin
    if (bus.en === 1'b1 && bus.addr < 16'(MEM_SZ)) begin
      if (bus.we) mem[bus.addr[7:0]] <= bus.dataW;
      else        bus.dataR <= mem[bus.addr[7:0]];
    end
  end

  // monitor: every access must be in range, every write must match the scoreboard head
  always @(negedge clk) begin
    if (bus.en === 1'b1) begin
      check("addr_range", 32'(bus.addr >= 16'(BASE) && bus.addr < 16'(BASE + NW)), 32'd1);
      if (bus.we) begin
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got write to 0x%04h, expected no write", bus.addr);
        end else begin
          check("wr_addr", 32'(bus.addr), 32'(exp_addr_q.pop_front()));
          check("wr_data", bus.dataW, exp_data_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] w, input logic [7:0] thr,
                                           output int hits);
    logic [7:0]  px [4];
    logic [31:0] r;
    r    = 32'd0;
    hits = 0;
    for (int k = 0; k < 4; k++) begin
      px[k] = w[8*k +: 8];
      if (px[k] >= thr) begin
        r[8*k +: 8] = 8'hFF;
        hits++;
      end
    end
    return r;
  endfunction

  task automatic load(input int mode);
    for (int a = 0; a < int'(MEM_SZ); a++) mem[a] = $urandom;
    for (int w = 0; w < int'(NW); w++) begin
      case (mode)
        0: mem[BASE + w] = 32'h80407F81;
        1: mem[BASE + w] = 32'h00000000;
        2: mem[BASE + w] = (w == 0) ? 32'h00FF0000 : 32'h00000000;
        3: mem[BASE + w] = 32'h20202020;
        default: mem[BASE + w] = $urandom;
      endcase
    end
    for (int a = 0; a < int'(MEM_SZ); a++) shadow[a] = mem[a];
  endtask

  task automatic run(input logic [7:0] thr, input int thr_at, input logic [7:0] thr2,
                     input int abort_at, input bit toggle, input bit hold);
    int          exp_cnt;
    int          h;
    int          edges;
    int          bad;
    bit          done;
    logic [31:0] exp_mem [NW];
    exp_cnt = 0;
    edges   = 0;
    done    = 1'b0;
    for (int w = 0; w < int'(NW); w++) begin
      exp_mem[w] = ref_word(mem[BASE + w], thr, h);
      exp_cnt   += h;
      exp_addr_q.push_back(16'(BASE + w));
      exp_data_q.push_back(exp_mem[w]);
    end
    @(negedge clk);
    start     = 1'b1;
    threshold = thr;
    while (!done && edges < int'(4 * NW + 20)) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check("abort_en", 32'(bus.en), 32'd0);
        check("abort_we", 32'(bus.we), 32'd0);
        check("abort_finish", 32'(finish), 32'd0);
        check("abort_edge_count", 32'(edge_count), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (finish) done = 1'b1;
      if (!hold) start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
      if (edges == thr_at) threshold = thr2;
    end
    check("finish_latency", done ? 32'(edges) : 32'd0, 32'(2 * NW + 1));
    if (hold) begin
      repeat (4) @(negedge clk);
      check("finish_hold", 32'(finish), 32'd1);
    end
    @(negedge clk);
    check("edge_count_done", 32'(edge_count), 32'(exp_cnt));
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("finish_idle", 32'(finish), 32'd0);
    check("edge_count_idle", 32'(edge_count), 32'(exp_cnt));
    bad = 0;
    for (int w = 0; w < int'(NW); w++) if (mem[BASE + w] !== exp_mem[w]) bad++;
    check("region_words_wrong", 32'(bad), 32'd0);
    bad = 0;
    for (int a = 0; a < int'(MEM_SZ); a++)
      if ((a < int'(BASE) || a >= int'(BASE + NW)) && mem[a] !== shadow[a]) bad++;
    check("outside_words_touched", 32'(bad), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #1;
    check("rst_en", 32'(bus.en), 32'd0);
    check("rst_we", 32'(bus.we), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_edge_count", 32'(edge_count), 32'd0);
    check("rst_addr", 32'(bus.addr), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    load(0); run(8'h80, 0, 8'h00, 0, 1'b0, 1'b0);
    load(1); run(8'h00, 0, 8'h00, 0, 1'b0, 1'b0);
    load(2); run(8'hFF, 0, 8'h00, 0, 1'b0, 1'b0);
    load(3); run(8'h10, 5, 8'hF0, 0, 1'b0, 1'b0);

    load(4); run(8'($urandom), 0, 8'h00, 10, 1'b0, 1'b0);
    run(8'($urandom), 0, 8'h00, 0, 1'b1, 1'b0);

    load(4); run(8'($urandom), 0, 8'h00, 0, 1'b0, 1'b1);
    load(4); run(8'($urandom), 0, 8'h00, 0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      load(4);
      run(8'($urandom), int'($urandom_range(1, 40)), 8'($urandom), 0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/edge_threshold.md
EDGE_THRESHOLD -- requirements
Module: edge_threshold

Interface
REQ-001 Parameter: BASE_ADDR, 25344, word address of first edge-image word.
REQ-002 Parameter: NUM_WORDS, 25344, number of 32-bit words processed (352x288 pixels, 4 pixels/word).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 addr  out  16  word address to memory.
REQ-006 dataR  in  32  read data, valid the cycle after a read request.
REQ-007 dataW  out  32  write data.
REQ-008 en  out  1  memory request.
REQ-009 we  out  1  1 = write, 0 = read; meaningful only with en=1.
REQ-010 start  in  1  level request to run; sampled in IDLE.
REQ-011 threshold  in  8  binarisation threshold; captured on accepted start.
REQ-012 finish  out  1  high while in DONE.
REQ-013 edge_count  out  17  number of pixels binarised to 0xFF in last run.

Function
REQ-014 Block SHALL post-process the Sobel output region in place: each pixel p >= thr_reg becomes 0xFF, else 0x00.
REQ-015 Pixel k of a word SHALL occupy bits [8k+7:8k], k=0 leftmost; byte order SHALL be preserved on write-back.
REQ-016 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-017 IDLE: en=0, we=0, addr=0, dataW=0, finish=0; start=1 -> READ, word index idx<=0, thr_reg<=threshold, edge_count<=0.
REQ-018 READ: en=1, we=0, addr=BASE_ADDR+idx; unconditional -> WRITE.
REQ-019 WRITE: en=1, we=1, addr=BASE_ADDR+idx, dataW=binarised dataR; edge_count += number of 0xFF bytes in dataW (0..4).
REQ-020 WRITE with idx=NUM_WORDS-1 -> DONE; otherwise idx<=idx+1 -> READ.
REQ-021 Throughput SHALL be exactly 2 cycles per word; run from accepted start to first DONE cycle = 2*NUM_WORDS+1 cycles (50689 default).
REQ-022 DONE: en=0, we=0, finish=1, edge_count held; start=1 stays DONE; start=0 -> IDLE.
REQ-023 edge_count SHALL hold its value in IDLE and DONE until the next accepted start.
REQ-024 threshold changes after start acceptance SHALL have no effect on the current run.
REQ-025 threshold=0 SHALL yield all pixels 0xFF; threshold=255 SHALL mark only pixels equal to 255.
REQ-026 idx SHALL be 15 bits wide; addr arithmetic SHALL be 16-bit, no wrap occurs for default parameters (max addr 50687).
REQ-027 start toggling during READ/WRITE SHALL be ignored.
REQ-028 No address outside [BASE_ADDR, BASE_ADDR+NUM_WORDS-1] SHALL be accessed with en=1.

Reset
REQ-029 reset SHALL force IDLE, idx=0, thr_reg=0, edge_count=0, finish=0, en=0, we=0 immediately, independent of clk.
REQ-030 reset mid-run SHALL abort; partially rewritten memory is accepted; next start reprocesses from idx=0.

Structure
REQ-031 Shared package SHALL hold IMG_WIDTH=352, IMG_HEIGHT=288, WORDS_PER_ROW=88, IMG_WORDS=25344, RESULT_BASE=25344 and the state enum type.
REQ-032 One combinational sub-module pix_thresh4 SHALL binarise 4 bytes against thr_reg and return the 32-bit word plus a 3-bit ones-count.
REQ-033 FSM, idx counter, thr_reg and edge_count accumulator SHALL reside in edge_threshold.

Verification
REQ-034 Memory words 25344..50687 = 0x80407F81, threshold=0x80 -> every word 0xFF0000FF, edge_count=50688, finish after 50689 cycles.
REQ-035 All zeros region, threshold=0 -> all words 0xFFFFFFFF, edge_count=101376.
REQ-036 Word 25344=0x00FF0000, rest 0, threshold=255 -> word 25344 = 0x00FF0000, others 0, edge_count=1; addresses 0..25343 untouched.
REQ-037 threshold changed 0x10->0xF0 five cycles after start, pixels 0x20 -> all 0xFF (0x10 used), edge_count=101376.
REQ-038 reset asserted at cycle 1000 of run -> en=0, finish=0, edge_count=0 same cycle; restart completes with correct full result.
REQ-039 start held high through DONE -> finish stays 1, no new run; start low then high -> second run, edge_count recomputed from 0.
